// File: rtl/formula_reducer.sv
// formula_reducer: applies one literal to a CNF formula, one clause per clock, dropping satisfied clauses and compacting the rest.
// Ports: clock/reset (async active-low); start+in_formula+lit_in request a reduction;
// busy/done handshake; out_formula with conflict (empty clause) and sat (no clauses) flags.
// Packing: lit={var[2:0],pol}; clause lit k at [3+4k +: 4], count [2:0]; formula clause k at [4+23k +: 23], count [3:0].
module formula_reducer (
  input  logic         clock,
  input  logic         reset,
  input  logic [233:0] in_formula,
  input  logic         start,
  input  logic [3:0]   lit_in,
  output logic         busy,
  output logic         done,
  output logic         conflict,
  output logic         sat,
  output logic [233:0] out_formula
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  state_e state_q, state_d;
  logic [3:0] rd_q, rd_d, wr_q, wr_d, l_q, l_d, n, lk;
  logic [233:0] f_q, f_d, out_q, out_d;
  logic conf_q, conf_d, sat_q, sat_d, hit;
  logic [22:0] cur;
  logic [19:0] keep;
  logic [2:0] cnt, nc;
  always_comb begin
    cur = '0;
    for (int i = 0; i < 10; i++) cur = (rd_q == 4'(i)) ? f_q[4+23*i +: 23] : cur;
    cnt = cur[2:0] > 3'd5 ? 3'd5 : cur[2:0];
    n = f_q[3:0] > 4'd10 ? 4'd10 : f_q[3:0];
    hit = 1'b0;
    keep = '0;
    nc = '0;
    lk = '0;
    for (int k = 0; k < 5; k++) begin
      lk = cur[3+4*k +: 4];
      // a var-0 literal is "empty" and never matches anything
      if (3'(k) < cnt && l_q[3:1] != 3'd0 && lk == l_q) hit = 1'b1;
      else if (3'(k) < cnt && !(l_q[3:1] != 3'd0 && lk[3:1] == l_q[3:1])) begin
        keep = keep | (20'(lk) << {nc, 2'b00});
        nc = nc + 3'd1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rd_d = rd_q;
    wr_d = wr_q;
    f_d = f_q;
    l_d = l_q;
    out_d = out_q;
    conf_d = conf_q;
    sat_d = sat_q;
    if (state_q == IDLE && start) begin
      f_d = in_formula;
      l_d = lit_in;
      rd_d = '0;
      wr_d = '0;
      out_d = '0;
      conf_d = 1'b0;
      sat_d = 1'b0;
      state_d = SCAN;
    end else if (state_q == SCAN && rd_q < n) begin
      rd_d = rd_q + 4'd1;
      if (!hit) begin
        for (int i = 0; i < 10; i++) if (wr_q == 4'(i)) out_d[4+23*i +: 23] = {keep, nc};
        wr_d = wr_q + 4'd1;
        conf_d = conf_q | (nc == 3'd0);
      end
    end else if (state_q == SCAN) begin
      out_d[3:0] = wr_q;
      sat_d = wr_q == 4'd0;
      state_d = DONE;
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rd_q <= '0;
      wr_q <= '0;
      f_q <= '0;
      l_q <= '0;
      out_q <= '0;
      conf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      f_q <= f_d;
      l_q <= l_d;
      out_q <= out_d;
      conf_q <= conf_d;
      sat_q <= sat_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign conflict = conf_q;
  assign sat = sat_q;
  assign out_formula = out_q;
endmodule

// File: tb/tb_formula_reducer.sv
// tb_formula_reducer: table vectors, corner sequences and random formulas against a queue-based model.
module tb_formula_reducer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done, conflict, sat;
  logic [233:0] in_formula = '0, out_formula;
  logic [3:0] lit_in = '0;
  int total = 0, bad = 0;

  formula_reducer dut (
    .clock(clk), .reset(rst_n), .in_formula(in_formula), .start(start), .lit_in(lit_in),
    .busy(busy), .done(done), .conflict(conflict), .sat(sat), .out_formula(out_formula)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [233:0] f;
    logic [3:0]   l;
    logic [233:0] o;
    logic         c;
    logic         s;
  } vec_t;
  vec_t tv[6];

  function automatic logic [3:0] L(int v, int p);
    return {3'(v), 1'(p)};
  endfunction

  function automatic logic [22:0] C(logic [3:0] a, b, c, d, e, int n);
    return {e, d, c, b, a, 3'(n)};
  endfunction

  function automatic logic [233:0] mkf(int n, logic [22:0] c0, c1, c2, c3);
    return {138'b0, c3, c2, c1, c0, 4'(n)};
  endfunction

  // Reference: walk the clauses as literal lists, filtering with a queue.
  function automatic void model(input logic [233:0] f, input logic [3:0] l,
                                output logic [233:0] o, output logic cf, output logic st);
    int n, m, w;
    logic [3:0] q[$];
    logic [3:0] x;
    logic [22:0] cl;
    bit drop;
    o = '0; cf = 0; w = 0;
    n = f[3:0] > 10 ? 10 : int'(f[3:0]);
    for (int i = 0; i < n; i++) begin
      cl = f[4+23*i +: 23];
      m = cl[2:0] > 5 ? 5 : int'(cl[2:0]);
      q.delete();
      drop = 0;
      for (int k = 0; k < m; k++) begin
        x = cl[3+4*k +: 4];
        if (l[3:1] != 0 && x == l) drop = 1;
        else if (!(l[3:1] != 0 && x[3:1] == l[3:1])) q.push_back(x);
      end
      if (!drop) begin
        cl = '0;
        foreach (q[j]) cl[3+4*j +: 4] = q[j];
        cl[2:0] = 3'(q.size());
        o[4+23*w +: 23] = cl;
        w++;
        if (q.size() == 0) cf = 1;
      end
    end
    o[3:0] = 4'(w);
    st = (w == 0);
  endfunction

  task automatic chk(string nm, logic [233:0] a, logic [233:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic run(string nm, logic [233:0] f, logic [3:0] l, logic [233:0] eo, logic ec, logic es);
    int lat, cyc;
    lat = (f[3:0] > 10 ? 10 : int'(f[3:0])) + 1;
    @(negedge clk);
    in_formula = f; lit_in = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    chk({nm, "_busy"}, 234'(busy), 234'(1));
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, 234'(cyc), 234'(lat));
    chk({nm, "_out"}, out_formula, eo);
    chk({nm, "_conflict"}, 234'(conflict), 234'(ec));
    chk({nm, "_sat"}, 234'(sat), 234'(es));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 234'({busy, done}), 234'(0));
    chk({nm, "_held"}, out_formula, eo);
  endtask

  logic [3:0] x1, x2, x5, nx1, nx2, nx5, x3, nx3, x4;
  logic [233:0] f1, rf, ro;
  logic rc, rs;
  int ndone;

  initial begin
    x1 = L(1,1); x2 = L(2,1); x5 = L(5,1); nx1 = L(1,0); nx2 = L(2,0); nx5 = L(5,0);
    x3 = L(3,1); nx3 = L(3,0); x4 = L(4,1);
    f1 = mkf(4, C(x1,x2,x5,0,0,3), C(nx2,nx5,0,0,0,2), C(nx1,nx2,nx5,0,0,3), C(x1,x2,0,0,0,2));
    tv[0] = '{"pos_x1", f1, x1, mkf(2, C(nx2,nx5,0,0,0,2), C(nx2,nx5,0,0,0,2), 0, 0), 0, 0};
    tv[1] = '{"neg_x5", f1, nx5, mkf(2, C(x1,x2,0,0,0,2), C(x1,x2,0,0,0,2), 0, 0), 0, 0};
    tv[2] = '{"conflict", mkf(2, C(x3,0,0,0,0,1), C(x4,nx3,0,0,0,2), 0, 0), nx3, mkf(1, 0, 0, 0, 0), 1, 0};
    tv[3] = '{"sat_one", mkf(1, C(x1,x2,0,0,0,2), 0, 0, 0), x2, '0, 0, 1};
    tv[4] = '{"zero_count", '0, x1, '0, 0, 1};
    tv[5] = '{"var0", f1, 4'b0000, f1, 0, 0};

    #1;
    chk("reset_out", out_formula, '0);
    chk("reset_flags", 234'({busy, done, conflict, sat}), 234'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) run(tv[i].nm, tv[i].f, tv[i].l, tv[i].o, tv[i].c, tv[i].s);

    // asynchronous reset two cycles into a four-clause scan
    @(negedge clk);
    in_formula = f1; lit_in = x1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_out", out_formula, '0);
    chk("midscan_reset_flags", 234'({busy, done, conflict, sat}), 234'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("reset_no_done", 234'(ndone), 234'(0));

    // start pulsed during SCAN must be ignored
    @(negedge clk);
    in_formula = f1; lit_in = x1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_formula = tv[2].f; lit_in = nx3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("ignored_start_out", out_formula, tv[0].o);
      end
    end
    chk("ignored_start_ndone", 234'(ndone), 234'(1));

    // random formulas, including counts beyond 10 and clause counts beyond 5
    repeat (150) begin
      rf = '0;
      for (int i = 0; i < 10; i++) begin
        for (int k = 0; k < 5; k++) rf[4+23*i+3+4*k +: 4] = L($urandom_range(0,5), $urandom_range(0,1));
        rf[4+23*i +: 3] = 3'($urandom_range(0,7));
      end
      rf[3:0] = 4'($urandom_range(0,12));
      lit_in = L($urandom_range(0,5), $urandom_range(0,1));
      model(rf, lit_in, ro, rc, rs);
      run("rand", rf, lit_in, ro, rc, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
